// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_operand_sequencer: gathers four complex operand pairs, starts the MAC, |
// | captures its result on a mac_ready rising edge.        Revision: 1.0       |
// +----------------------------------------------------------------------------+
module mac_operand_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int START_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_x_i,
    input  logic [7:0]  in_y_i,
    output logic [31:0] mac_x_o,
    output logic [31:0] mac_y_o,
    output logic        mac_start_o,
    input  logic [19:0] mac_res_i,
    input  logic        mac_ready_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [9:0]  out_real_o,
    output logic [9:0]  out_imag_o,
    output logic        busy_o,
    output logic        err_timeout_o
);

    localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SCW-1:0] S_LAST = SCW'(START_CYC - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    x_q, x_d;
    logic [31:0]    y_q, y_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [9:0]     real_q, real_d;
    logic [9:0]     imag_q, imag_d;
    logic           err_q, err_d;
    logic           prev_q;
    logic           in_ready_q;
    logic           mac_start_q;
    logic           out_valid_q;
    logic           busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        scnt_d  = scnt_q;
        wcnt_d  = wcnt_q;
        real_d  = real_q;
        imag_d  = imag_q;
        err_d   = err_q;
        unique case (state_q)
            S_LOAD: begin
                if (in_valid_i && in_ready_q) begin
                    x_d[{cnt_q, 3'b000} +: 8] = in_x_i;
                    y_d[{cnt_q, 3'b000} +: 8] = in_y_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_START;
                        scnt_d  = '0;
                    end
                end
            end
            S_START: begin
                if (scnt_q == S_LAST) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Only a fresh low-to-high transition counts as MAC completion.
                if (mac_ready_i && !prev_q) begin
                    real_d  = mac_res_i[19:10];
                    imag_d  = mac_res_i[9:0];
                    state_d = S_HOLD;
                end else if (wcnt_q == W_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            scnt_q      <= '0;
            wcnt_q      <= '0;
            real_q      <= '0;
            imag_q      <= '0;
            err_q       <= 1'b0;
            prev_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mac_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            scnt_q      <= scnt_d;
            wcnt_q      <= wcnt_d;
            real_q      <= real_d;
            imag_q      <= imag_d;
            err_q       <= err_d;
            prev_q      <= mac_ready_i;
            in_ready_q  <= (state_d == S_LOAD);
            mac_start_q <= (state_d == S_START);
            out_valid_q <= (state_d == S_HOLD);
            busy_q      <= (state_d != S_LOAD);
        end
    end

    assign in_ready_o    = in_ready_q;
    assign mac_x_o       = x_q;
    assign mac_y_o       = y_q;
    assign mac_start_o   = mac_start_q;
    assign out_valid_o   = out_valid_q;
    assign out_real_o    = real_q;
    assign out_imag_o    = imag_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mac_operand_sequencer: directed bench with a cycle model of the        |
// | sequencer's transaction rules.                          Revision: 1.0      |
// +----------------------------------------------------------------------------+
module tb_mac_operand_sequencer;

    localparam int TIMEOUT   = 255;
    localparam int START_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [31:0] mac_x;
    logic [31:0] mac_y;
    logic        mac_start;
    logic [19:0] mac_res;
    logic        mac_ready;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_real;
    logic [9:0]  out_imag;
    logic        busy;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mac_operand_sequencer #(.TIMEOUT(TIMEOUT), .START_CYC(START_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_x_i       (in_x),
        .in_y_i       (in_y),
        .mac_x_o      (mac_x),
        .mac_y_o      (mac_y),
        .mac_start_o  (mac_start),
        .mac_res_i    (mac_res),
        .mac_ready_i  (mac_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_real_o   (out_real),
        .out_imag_o   (out_imag),
        .busy_o       (busy),
        .err_timeout_o(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=load 1=start 2=wait 3=hold, plus the four gathered slots.
    int         m_phase;
    int         m_taken;
    int         m_start_left;
    int         m_waited;
    logic [7:0] m_sx[4];
    logic [7:0] m_sy[4];
    logic       m_prev;
    logic       m_err;
    logic [9:0] m_real;
    logic [9:0] m_imag;
    logic       e_in_ready;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0;
            m_taken = 0;
            m_start_left = 0;
            m_waited = 0;
            for (int i = 0; i < 4; i++) begin
                m_sx[i] = 8'h00;
                m_sy[i] = 8'h00;
            end
            m_prev = 1'b0;
            m_err = 1'b0;
            m_real = 10'h0;
            m_imag = 10'h0;
            e_in_ready = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid && e_in_ready) begin
                    m_sx[m_taken] = in_x;
                    m_sy[m_taken] = in_y;
                    m_taken++;
                    if (m_taken == 4) begin
                        m_taken = 0;
                        m_phase = 1;
                        m_start_left = START_CYC;
                    end
                end
                1: begin
                    m_start_left--;
                    if (m_start_left == 0) begin
                        m_phase = 2;
                        m_waited = 0;
                    end
                end
                2: if (mac_ready && !m_prev) begin
                    m_real = mac_res[19:10];
                    m_imag = mac_res[9:0];
                    m_phase = 3;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        m_err = 1'b1;
                        m_phase = 0;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
            m_prev = mac_ready;
            e_in_ready = (m_phase == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, e_in_ready);
            chk("mac_start", mac_start, m_phase == 1);
            chk("busy", busy, m_phase != 0);
            chk("out_valid", out_valid, m_phase == 3);
            chk("err_timeout", err_timeout, m_err);
            chk("out_real", out_real, m_real);
            chk("out_imag", out_imag, m_imag);
            chk("mac_x", mac_x, {m_sx[3], m_sx[2], m_sx[1], m_sx[0]});
            chk("mac_y", mac_y, {m_sy[3], m_sy[2], m_sy[1], m_sy[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        step();
        in_valid = 1'b0;
    endtask

    task automatic capture(input logic [19:0] res);
        mac_ready = 1'b1;
        mac_res = res;
        step();
        mac_ready = 1'b0;
    endtask

    int n_start;
    int xfers;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_x = 8'h0; in_y = 8'h0;
        mac_res = 20'h0; mac_ready = 1'b0; out_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst busy", busy, 1'b0);
        rst = 1'b1;
        step();
        chk("release in_ready", in_ready, 1'b1);

        // Back-to-back load, start pulse length, result capture latency.
        for (int i = 0; i < 4; i++) push(8'h12, 8'h34);
        chk("t1 mac_x", mac_x, 32'h12121212);
        chk("t1 mac_y", mac_y, 32'h34343434);
        n_start = 0;
        repeat (5) begin
            if (mac_start) n_start++;
            step();
        end
        chk("t1 start cycles", n_start, 2);
        mac_ready = 1'b1;
        mac_res = {10'h3EC, 10'd40};
        chk("t1 pre-edge out_valid", out_valid, 1'b0);
        step();
        mac_ready = 1'b0;
        chk("t1 out_valid", out_valid, 1'b1);
        chk("t1 out_real", out_real, 10'h3EC);
        chk("t1 out_imag", out_imag, 10'd40);
        out_ready = 1'b1;
        step();
        chk("t1 done out_valid", out_valid, 1'b0);
        chk("t1 done in_ready", in_ready, 1'b1);

        // Gapped load, with a stray mac_ready pulse while loading.
        begin
            logic [7:0] gx[4];
            logic [7:0] gy[4];
            gx = '{8'h70, 8'h07, 8'h77, 8'h11};
            gy = '{8'h70, 8'h70, 8'h07, 8'h11};
            for (int i = 0; i < 4; i++) begin
                push(gx[i], gy[i]);
                if (i < 3) begin
                    chk("t2 no start", mac_start, 1'b0);
                    mac_ready = (i == 1);
                    step();
                    mac_ready = 1'b0;
                    step();
                end
            end
        end
        chk("t2 start", mac_start, 1'b1);
        chk("t2 mac_x", mac_x, 32'h11770770);
        chk("t2 mac_y", mac_y, 32'h11077070);
        repeat (START_CYC + 1) step();
        capture({10'h1FF, 10'h200});
        chk("t2 out_real", out_real, 10'h1FF);
        step();
        out_ready = 1'b0;

        // mac_ready high throughout: no edge, so the wait must time out.
        mac_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hA5, 8'h5A);
        repeat (TIMEOUT + 1) step();
        chk("t3 err before", err_timeout, 1'b0);
        chk("t3 busy before", busy, 1'b1);
        step();
        chk("t3 err", err_timeout, 1'b1);
        chk("t3 out_valid", out_valid, 1'b0);
        chk("t3 in_ready", in_ready, 1'b1);
        chk("t3 out_real kept", out_real, 10'h1FF);
        mac_ready = 1'b0;
        step();

        // Long HOLD with back-pressure and in_valid asserted.
        for (int i = 0; i < 4; i++) push(8'h9C, 8'h3D);
        repeat (START_CYC + 1) step();
        capture({10'h155, 10'h2AA});
        in_valid = 1'b1;
        in_x = 8'hEE;
        in_y = 8'hEE;
        repeat (10) begin
            chk("t4 out_valid", out_valid, 1'b1);
            chk("t4 in_ready", in_ready, 1'b0);
            chk("t4 out_real", out_real, 10'h155);
            chk("t4 out_imag", out_imag, 10'h2AA);
            step();
        end
        out_ready = 1'b1;
        xfers = 0;
        repeat (3) begin
            if (out_valid && out_ready) xfers++;
            step();
            in_valid = 1'b0;
        end
        chk("t4 transfers", xfers, 1);
        chk("t4 err sticky", err_timeout, 1'b1);
        out_ready = 1'b0;

        // Reset in the second START cycle, then partial load discarded by reset.
        for (int i = 0; i < 4; i++) push(8'h21, 8'h43);
        step();
        rst = 1'b0;
        step();
        chk("t5 mac_start", mac_start, 1'b0);
        chk("t5 err", err_timeout, 1'b0);
        chk("t5 mac_x", mac_x, 32'h0);
        chk("t5 out_real", out_real, 10'h0);
        chk("t5 in_ready", in_ready, 1'b0);
        rst = 1'b1;
        step();
        chk("t5 in_ready after", in_ready, 1'b1);
        push(8'hFF, 8'hFF);
        push(8'hFF, 8'hFF);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        push(8'h01, 8'h10);
        push(8'h02, 8'h20);
        push(8'h03, 8'h30);
        chk("t5 no early start", mac_start, 1'b0);
        push(8'h04, 8'h40);
        chk("t5 start", mac_start, 1'b1);
        chk("t5 fresh mac_x", mac_x, 32'h04030201);
        chk("t5 fresh mac_y", mac_y, 32'h40302010);
        repeat (START_CYC + 1) step();
        capture({10'h200, 10'h001});
        chk("t5 out_real", out_real, 10'h200);
        chk("t5 out_imag", out_imag, 10'h001);
        out_ready = 1'b1;
        step();
        chk("t5 done", out_valid, 1'b0);
        out_ready = 1'b0;
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles spent in WAIT before abort.
REQ-002 Parameter START_CYC, default 2: cycles mac_start is held high.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  sequencer accepts a pair.
REQ-008 in_x  in  8  complex X; real [7:4], imag [3:0].
REQ-009 in_y  in  8  complex Y; same packing as in_x.
REQ-010 mac_x  out  32  X0..X3 to MAC; Xk = mac_x[8k+7:8k].
REQ-011 mac_y  out  32  Y0..Y3 to MAC; same slicing.
REQ-012 mac_start  out  1  MAC start request.
REQ-013 mac_res  in  20  MAC result; signed real [19:10], signed imag [9:0].
REQ-014 mac_ready  in  1  MAC done indication.
REQ-015 out_valid  out  1  captured result available.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 out_real  out  10  signed real part of captured result.
REQ-018 out_imag  out  10  signed imag part of captured result.
REQ-019 busy  out  1  high in any state other than LOAD.
REQ-020 err_timeout  out  1  sticky; set when WAIT times out.

Function
REQ-021 The FSM SHALL have states LOAD, START, WAIT and HOLD; all outputs SHALL be registered.
REQ-022 LOAD: in_ready=1. Each cycle with in_valid&&in_ready SHALL write in_x/in_y into slot cnt (2-bit, 0..3) and increment cnt.
REQ-023 The 4th accept SHALL wrap cnt to 0 and enter START on the same edge. Pairs are not accepted in START, WAIT or HOLD (in_ready=0).
REQ-024 Slot k SHALL drive mac_x/mac_y byte k. Operand registers change only on an accept in LOAD, so they are stable through START and WAIT.
REQ-025 START: mac_start=1 for exactly START_CYC cycles, beginning the cycle after the 4th accept. The block then enters WAIT with mac_start=0.
REQ-026 A prev_ready register SHALL sample mac_ready every cycle.
REQ-027 WAIT: a rising edge (mac_ready=1, prev_ready=0) SHALL capture mac_res[19:10] into out_real and mac_res[9:0] into out_imag, unmodified, and enter HOLD on that edge. A mac_ready level that is continuously high into WAIT SHALL NOT trigger capture.
REQ-028 WAIT timeout: a counter cleared on entry SHALL count cycles. On reaching TIMEOUT without an edge, the block SHALL set err_timeout, leave out_real/out_imag unchanged, and return to LOAD.
REQ-029 HOLD: out_valid=1. out_real/out_imag SHALL stay stable until out_valid&&out_ready, then clear out_valid and return to LOAD.
REQ-030 out_ready high in the first HOLD cycle SHALL complete the transfer in that cycle, giving one-cycle out_valid.
REQ-031 out_ready outside HOLD SHALL be ignored.
REQ-032 Latency: the first out_valid cycle SHALL be exactly one cycle after the capturing edge.
REQ-033 A mac_ready edge seen in LOAD or START SHALL be ignored.
REQ-034 err_timeout SHALL be cleared only by reset.

Reset
REQ-035 On any edge with rst=0, regardless of state, the block SHALL set state=LOAD, cnt=0, operand registers=0, mac_start=0, out_valid=0, out_real=0, out_imag=0, busy=0, err_timeout=0, prev_ready=0 and counters=0. in_ready SHALL be 0 during reset and 1 on the first cycle after rst returns high.
REQ-036 Reset asserted mid-START SHALL deassert mac_start on that same edge. Pairs accepted before reset SHALL be discarded.

Verification
REQ-037 Four pairs X=0x12, Y=0x34, back-to-back; MAC model gives a ready edge with mac_res={-20,40} -> mac_x=0x12121212, mac_y=0x34343434; mac_start high for 2 cycles; out_real=-20, out_imag=40 one cycle after the edge.
REQ-038 Pairs with gaps (in_valid low between accepts), X={0x70,0x07,0x77,0x11}, Y={0x70,0x70,0x07,0x11} -> mac_x=0x11770770, mac_y=0x11077070; no start until the 4th accept.
REQ-039 mac_ready held high throughout and never toggled -> no capture; err_timeout=1 after 255 WAIT cycles; return to LOAD with out_valid=0.
REQ-040 out_ready held low for 10 cycles in HOLD, with in_valid held high -> out_valid and data stable and in_ready=0 throughout; exactly one transfer when out_ready rises.
REQ-041 rst=0 in the 2nd START cycle -> mac_start=0 next cycle; all outputs at reset values; a fresh 4-pair load then works normally.
